// File: rtl/sprite_pkg.sv
// Shared types and the RGB888 -> RGB332 encoder for the sprite write path.
package sprite_pkg;

    typedef logic [23:0] rgb888_t;
    typedef logic [7:0]  pal_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SWAP  = 2'd2
    } writer_state_t;

    // Plain truncation; the palette memory holds the matching RGB332 table.
    function automatic pal_idx_t rgb_to_rgb332(input rgb888_t px);
        return {px[23:21], px[15:13], px[7:6]};
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Pixel x/y counters and back-buffer address generation for the sprite writer.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT * 2)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              advance_i,
    input  logic              restart_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_pixel_o
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [XW-1:0]     x_q, x_d, cur_x;
    logic [YW-1:0]     y_q, y_d, cur_y;
    logic              x_at_end, y_at_end;
    logic [ADDR_W-1:0] back_base;

    // A restart treats the current pixel as (0,0) regardless of the counters.
    assign cur_x    = restart_i ? '0 : x_q;
    assign cur_y    = restart_i ? '0 : y_q;
    assign x_at_end = (cur_x == XW'(WIDTH - 1));
    assign y_at_end = (cur_y == YW'(HEIGHT - 1));

    assign last_pixel_o = x_at_end && y_at_end;
    assign back_base    = pop_i ? ADDR_W'(WIDTH * HEIGHT) : '0;
    assign addr_o       = back_base + ADDR_W'(cur_y) * ADDR_W'(WIDTH) + ADDR_W'(cur_x);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance_i) begin
            if (x_at_end) begin
                x_d = '0;
                y_d = y_at_end ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/sprite_frame_writer.sv
// Streams RGB888 frames into the back half of the double-buffered sprite BRAM
// as RGB332 indices and flips the front-buffer select at end of frame.
module sprite_frame_writer
    import sprite_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT * 2)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic              s_valid_in,
    output logic              s_ready_out,
    input  logic [23:0]       s_data_in,
    input  logic              s_sof_in,
    input  logic              swap_en_in,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [7:0]        mem_data_out,
    output logic              pop_out,
    output logic              frame_done_out,
    output logic              sync_err_out
);

    writer_state_t     state_q, state_d;
    logic              pop_q, pop_d;
    logic              sync_err_q, sync_err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    pal_idx_t          mem_data_q, mem_data_d;

    logic              xfer, advance, restart, last_pixel;
    logic [ADDR_W-1:0] gen_addr;

    assign s_ready_out = (state_q != SWAP);
    assign xfer        = s_valid_in & s_ready_out;

    // Any sof transfer (IDLE or mid-frame) restarts at (0,0); in IDLE, non-sof pixels are dropped.
    assign restart = xfer & s_sof_in & ((state_q == IDLE) | (state_q == WRITE));
    assign advance = xfer & (((state_q == IDLE) & s_sof_in) | (state_q == WRITE));

    sprite_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i        (pixel_clk_in),
        .rst_n_i      (rst_n_in),
        .advance_i    (advance),
        .restart_i    (restart),
        .pop_i        (pop_q),
        .addr_o       (gen_addr),
        .last_pixel_o (last_pixel)
    );

    always_comb begin
        state_d    = state_q;
        pop_d      = pop_q;
        sync_err_d = sync_err_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            IDLE: begin
                if (advance) state_d = last_pixel ? SWAP : WRITE;
            end
            WRITE: begin
                if (advance) begin
                    if (restart) sync_err_d = 1'b1;
                    state_d = last_pixel ? SWAP : WRITE;
                end
            end
            SWAP: begin
                // The last write lands during this cycle, before pop flips.
                if (swap_en_in) pop_d = ~pop_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            mem_we_d   = 1'b1;
            mem_addr_d = gen_addr;
            mem_data_d = rgb_to_rgb332(s_data_in);
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            pop_q      <= 1'b1;
            sync_err_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pop_q      <= pop_d;
            sync_err_q <= sync_err_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_we_out     = mem_we_q;
    assign mem_addr_out   = mem_addr_q;
    assign mem_data_out   = mem_data_q;
    assign pop_out        = pop_q;
    assign frame_done_out = (state_q == SWAP);
    assign sync_err_out   = sync_err_q;

endmodule

// File: tb/tb_sprite_frame_writer.sv
// Directed bench for sprite_frame_writer on a 4x2 frame.
module tb_sprite_frame_writer;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              s_valid_in;
    logic              s_ready_out;
    logic [23:0]       s_data_in;
    logic              s_sof_in;
    logic              swap_en_in;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [7:0]        mem_data_out;
    logic              pop_out;
    logic              frame_done_out;
    logic              sync_err_out;

    sprite_frame_writer #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .s_valid_in     (s_valid_in),
        .s_ready_out    (s_ready_out),
        .s_data_in      (s_data_in),
        .s_sof_in       (s_sof_in),
        .swap_en_in     (swap_en_in),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_out   (mem_data_out),
        .pop_out        (pop_out),
        .frame_done_out (frame_done_out),
        .sync_err_out   (sync_err_out)
    );

    typedef struct {
        logic [23:0] px;
        logic [7:0]  idx;
        logic [3:0]  off;
    } vec_t;

    vec_t tbl [8];
    int   total  = 0;
    int   passed = 0;
    int   fd_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done_out) fd_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [23:0] d, input logic sof);
        s_valid_in = 1'b1;
        s_data_in  = d;
        s_sof_in   = sof;
        @(posedge clk);
        #1;
        s_valid_in = 1'b0;
        s_sof_in   = 1'b0;
    endtask

    task automatic idle_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string nm, input logic [3:0] a, input logic [7:0] d);
        chk({nm, "_we"},   32'(mem_we_out),   32'd1);
        chk({nm, "_addr"}, 32'(mem_addr_out), 32'(a));
        chk({nm, "_data"}, 32'(mem_data_out), 32'(d));
    endtask

    // held: caller sits in the SWAP cycle and the first sof pixel is presented there.
    task automatic run_frame(input string nm, input logic [3:0] base, input bit gaps, input bit held);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
                idle_cyc();
                chk({nm, "_gap_we"},    32'(mem_we_out),  32'd0);
                chk({nm, "_gap_ready"}, 32'(s_ready_out), 32'd1);
            end
            if (i == 0 && held) begin
                s_valid_in = 1'b1;
                s_sof_in   = 1'b1;
                s_data_in  = tbl[0].px;
                chk({nm, "_swap_ready"}, 32'(s_ready_out), 32'd0);
                @(posedge clk);
                #1;
                chk({nm, "_held_we"}, 32'(mem_we_out), 32'd0);
            end
            push(tbl[i].px, i == 0);
            check_wr($sformatf("%s_px%0d", nm, i), base + tbl[i].off, tbl[i].idx);
            chk($sformatf("%s_done%0d", nm, i), 32'(frame_done_out), (i == 7) ? 32'd1 : 32'd0);
        end
        chk({nm, "_ready_swap"}, 32'(s_ready_out), 32'd0);
    endtask

    initial begin
        int fd_before;

        tbl[0] = '{24'hFFFFFF, 8'hFF, 4'd0};
        tbl[1] = '{24'h000000, 8'h00, 4'd1};
        tbl[2] = '{24'hE0E0C0, 8'hFF, 4'd2};
        tbl[3] = '{24'h204080, 8'h2A, 4'd3};
        tbl[4] = '{24'h800000, 8'h80, 4'd4};
        tbl[5] = '{24'h00FF00, 8'h1C, 4'd5};
        tbl[6] = '{24'h0000FF, 8'h03, 4'd6};
        tbl[7] = '{24'hC0A040, 8'hD5, 4'd7};

        rst_n      = 1'b0;
        s_valid_in = 1'b0;
        s_sof_in   = 1'b0;
        s_data_in  = '0;
        swap_en_in = 1'b1;
        #12;
        chk("rst_we",       32'(mem_we_out),     32'd0);
        chk("rst_addr",     32'(mem_addr_out),   32'd0);
        chk("rst_data",     32'(mem_data_out),   32'd0);
        chk("rst_pop",      32'(pop_out),        32'd1);
        chk("rst_done",     32'(frame_done_out), 32'd0);
        chk("rst_sync_err", 32'(sync_err_out),   32'd0);
        chk("rst_ready",    32'(s_ready_out),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cyc();

        // Swap enabled: first frame into buffer 1, second into buffer 0.
        run_frame("f1", 4'd8, 1'b0, 1'b0);
        idle_cyc();
        chk("f1_pop_after",  32'(pop_out),        32'd0);
        chk("f1_done_after", 32'(frame_done_out), 32'd0);
        chk("f1_we_after",   32'(mem_we_out),     32'd0);
        chk("f1_ready_after", 32'(s_ready_out),   32'd1);
        run_frame("f2", 4'd0, 1'b0, 1'b0);
        idle_cyc();
        chk("f2_pop_after", 32'(pop_out), 32'd1);

        // Swap disabled: both frames overwrite the same back buffer.
        swap_en_in = 1'b0;
        fd_before  = fd_cnt;
        run_frame("ns1", 4'd8, 1'b0, 1'b0);
        run_frame("ns2", 4'd8, 1'b0, 1'b1);
        idle_cyc();
        chk("ns_pop",     32'(pop_out),            32'd1);
        chk("ns_fd_count", 32'(fd_cnt - fd_before), 32'd2);

        // Non-sof pixels in IDLE are acknowledged but never written.
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drop%0d_ready", i), 32'(s_ready_out), 32'd1);
            push(24'hABCDEF, 1'b0);
            chk($sformatf("drop%0d_we", i), 32'(mem_we_out), 32'd0);
        end

        // sof after 5 pixels restarts the frame and flags a sync error.
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].px, i == 0);
            check_wr($sformatf("part_px%0d", i), 4'd8 + tbl[i].off, tbl[i].idx);
        end
        chk("part_sync_err_pre", 32'(sync_err_out), 32'd0);
        push(tbl[0].px, 1'b1);
        check_wr("resync_px0", 4'd8, tbl[0].idx);
        chk("resync_sync_err", 32'(sync_err_out), 32'd1);
        for (int i = 1; i < 8; i++) begin
            push(tbl[i].px, 1'b0);
            check_wr($sformatf("resync_px%0d", i), 4'd8 + tbl[i].off, tbl[i].idx);
            chk($sformatf("resync_done%0d", i), 32'(frame_done_out), (i == 7) ? 32'd1 : 32'd0);
        end
        idle_cyc();

        // Random valid gaps produce the same write sequence.
        run_frame("gap", 4'd8, 1'b1, 1'b0);
        idle_cyc();
        chk("gap_sync_err_sticky", 32'(sync_err_out), 32'd1);

        // Asynchronous reset in the middle of a frame.
        swap_en_in = 1'b1;
        run_frame("pre", 4'd8, 1'b0, 1'b0);
        idle_cyc();
        chk("pre_pop", 32'(pop_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            push(tbl[i].px, i == 0);
            check_wr($sformatf("mid_px%0d", i), tbl[i].off, tbl[i].idx);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",       32'(mem_we_out),   32'd0);
        chk("arst_pop",      32'(pop_out),      32'd1);
        chk("arst_addr",     32'(mem_addr_out), 32'd0);
        chk("arst_sync_err", 32'(sync_err_out), 32'd0);
        #3 rst_n = 1'b1;
        idle_cyc();
        chk("post_we", 32'(mem_we_out), 32'd0);
        run_frame("post", 4'd8, 1'b0, 1'b0);
        idle_cyc();
        chk("post_pop", 32'(pop_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
